sram_1rw_buffered: RTL
======================

Name: sram_1rw_buffered

Overview:
- Parametrised single-port (1RW) SRAM block: generic successor of the fixed 64x64 single-port macro wrapper.
- Adds per-byte write enables, a valid/ready request/response handshake with a 2-entry response buffer (full backpressure tolerance), and an optional post-reset zero-initialisation sweep.
- Sits between cache/predictor tables and the memory array. Callers never need to sample read data on a fixed cycle.

Parameters:
- WIDTH, 64, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; must be at least 2.
- AW, $clog2(DEPTH), address width (derived).
- INIT_ZERO, 1, if 1, sweep all words to zero after reset before accepting requests.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  WIDTH  write data
- req_be  in  WIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i]
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes response when resp_valid && resp_ready
- resp_rdata  out  WIDTH  read data, held stable while resp_valid && !resp_ready
- init_done  out  1  high once block is ready to accept requests

Behaviour:
- One clock; reset is asynchronous and active-high. Port names are clk and rst.
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, init_done=0. FSM, sweep counter, in-flight flag and response buffer are all cleared. Array contents are not reset.
- FSM states: INIT, RUN.
  - Reset enters INIT if INIT_ZERO=1, else RUN.
  - INIT: writes all-zero to address cnt each cycle, cnt 0..DEPTH-1. After writing DEPTH-1, moves to RUN. The sweep takes exactly DEPTH cycles after rst deasserts.
  - RUN: init_done=1. The block never leaves RUN except on reset.
  - Reset asserted mid-sweep or mid-transaction aborts immediately. In-flight reads and buffered responses are dropped. INIT restarts at address 0.
- Array: one access per cycle, shared by the sweep and requests.
  - Write: only bytes with req_be set are updated. req_be=0 is a legal no-op write.
  - Read: registered, one-cycle latency.
  - A read accepted in cycle N sees all writes accepted in cycles before N.
- Credit rule:
  - occ = buffered responses (0..2) + in-flight read (0/1).
  - req_ready = (state==RUN) && (occ - (resp_valid && resp_ready) < 2).
  - Writes and reads share the same req_ready. Writes consume no credit and produce no response.
  - req_ready must not combinationally depend on req_valid.
- Response buffer: 2-entry FIFO, fed by read data one cycle after acceptance.
  - resp_valid = FIFO not empty. resp_rdata = FIFO head.
  - Enqueue and dequeue in the same cycle are legal at any occupancy 0..2.
  - The FIFO never overflows, guaranteed by the credit rule.
- Throughput: with resp_ready held high, one read per cycle is sustained. First resp_valid appears one cycle after the first accept.
- Back-to-back write then read to the same address returns the written (byte-merged) data.
- Ordering: responses return in request order.
- Elaboration: assert on WIDTH%8!=0 or DEPTH<2.

Test Plan:
- Reset release with INIT_ZERO=1, DEPTH=64 -> init_done and req_ready rise exactly 64 cycles after rst falls. A read of each of addresses 0..63 returns 0.
- Write addr 5 data 0x1122334455667788 be=0xFF, then write addr 5 data 0xAAAA..AA be=0x0F, then read 5 -> resp_rdata = 0x11223344AAAAAAAA, one cycle after read accept.
- resp_ready held 0, issue reads to addrs 1, 2, 3 -> only two accepted, req_ready drops to 0. Raise resp_ready -> responses 1, 2 drain in order, then read 3 accepts. resp_rdata stays stable while stalled.
- resp_ready=1, 64 back-to-back reads -> req_ready stays 1. resp_valid is continuous for 64 cycles, in address order.
- Write addr 7 then read addr 7 on the next cycle -> new data is returned, no stale value.
- Assert rst while 2 responses are buffered and during the INIT sweep at cnt=30 -> resp_valid=0, req_ready=0, init_done=0 immediately (async). The sweep restarts at 0 and completes 64 cycles after release.

Source files
------------

// File: rtl/sram_1rw_buffered.sv
// Parametrised single-port SRAM with per-byte write enables, a valid/ready request
// port, a 2-entry response FIFO and an optional zero-fill sweep after reset.
module sram_1rw_buffered #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 64,
    parameter int AW        = $clog2(DEPTH),
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [AW-1:0]      req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_be,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               init_done
);

    localparam int NB = WIDTH / 8;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] fifo_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             rd_accept;
    logic             wr_accept;
    logic             deq;

    if ((WIDTH % 8) != 0 || DEPTH < 2) begin : g_param_check
        $error("sram_1rw_buffered: WIDTH must be a multiple of 8 and DEPTH at least 2");
    end

    // A response leaving this cycle frees its slot for a read accepted in the same cycle.
    assign deq        = (count != 2'd0) && resp_ready;
    assign req_ready  = init_done && ((count - {1'b0, deq}) < 2'd2);
    assign accept     = req_valid && req_ready;
    assign rd_accept  = accept && !req_write;
    assign wr_accept  = accept && req_write;
    assign resp_valid = (count != 2'd0);
    assign resp_rdata = fifo_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT_ZERO ? INIT : RUN;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // The array is never reset; the sweep owns the single port until RUN.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // The read is registered straight into the FIFO slot, giving one-cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else begin
            if (rd_accept) begin
                fifo_data[wr_ptr] <= mem[req_addr];
                wr_ptr            <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, rd_accept} - {1'b0, deq};
        end
    end

endmodule
